// File: rtl/lsu_core_if.sv
// Request-side (lsu_core_if) and memory-side (lsu_mem_if) signal bundles for lsu_core.
interface lsu_core_if;
    logic        reqValid;
    logic        reqReady;
    logic        is_store;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        respValid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output reqValid, is_store, size, is_unsigned, addr, wdata,
        input  reqReady, respValid, rdata, err
    );
    modport slave (
        input  reqValid, is_store, size, is_unsigned, addr, wdata,
        output reqReady, respValid, rdata, err
    );
endinterface

interface lsu_mem_if;
    logic        mem_reqValid;
    logic        mem_reqReady;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_respValid;
    logic [31:0] mem_rdata;
    logic        mem_respErr;

    modport master (
        output mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
        input  mem_reqReady, mem_respValid, mem_rdata, mem_respErr
    );
    modport slave (
        input  mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
        output mem_reqReady, mem_respValid, mem_rdata, mem_respErr
    );
endinterface

// File: rtl/lsu_core.sv
// Single-outstanding load/store unit: byte/half/word lane steering and load extension.
// Define LSU_MISALIGN_CHECK_EN to fail misaligned or size=3 accesses locally with err=1.
module lsu_core (
    input  logic      clock,
    input  logic      reset,
    lsu_core_if.slave cpu,
    lsu_mem_if.master mem
);
    typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_WAIT, LSU_RESP} lsu_state_e;

    lsu_state_e  state;
    lsu_state_e  state_next;

    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wstrb_q;
    logic        mem_wen_q;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic        store_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        resp_take;
    logic        misaligned;
    logic [31:0] store_data;
    logic [3:0]  store_strb;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign accept    = cpu.reqValid && (state == LSU_IDLE);
    assign resp_take = mem.mem_respValid && (state == LSU_WAIT);

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        case (cpu.size)
            2'd1:    misaligned = cpu.addr[0];
            2'd2:    misaligned = |cpu.addr[1:0];
            2'd3:    misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    // Replicate store data across the word so any enabled lane sees the right bytes.
    always_comb begin
        store_data = cpu.wdata;
        store_strb = 4'b1111;
        case (cpu.size)
            2'd0: begin
                store_data = {4{cpu.wdata[7:0]}};
                store_strb = 4'b0001 << cpu.addr[1:0];
            end
            2'd1: begin
                store_data = {2{cpu.wdata[15:0]}};
                store_strb = cpu.addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
        if (!cpu.is_store) store_strb = 4'b0000;
    end

    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = mem.mem_rdata[7:0];
            2'd1:    byte_sel = mem.mem_rdata[15:8];
            2'd2:    byte_sel = mem.mem_rdata[23:16];
            default: byte_sel = mem.mem_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (size_q)
            2'd0:    load_data = {{24{byte_sel[7] & ~unsigned_q}}, byte_sel};
            2'd1:    load_data = {{16{half_sel[15] & ~unsigned_q}}, half_sel};
            default: load_data = mem.mem_rdata;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= LSU_IDLE;
        else       state <= state_next;
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next       = state;
        cpu.reqReady     = 1'b0;
        cpu.respValid    = 1'b0;
        cpu.err          = 1'b0;
        mem.mem_reqValid = 1'b0;
        case (state)
            LSU_IDLE: begin
                cpu.reqReady = 1'b1;
                if (accept) state_next = misaligned ? LSU_RESP : LSU_REQ;
            end
            LSU_REQ: begin
                mem.mem_reqValid = 1'b1;
                if (mem.mem_reqReady) state_next = LSU_WAIT;
            end
            LSU_WAIT: begin
                if (mem.mem_respValid) state_next = LSU_RESP;
            end
            LSU_RESP: begin
                cpu.respValid = 1'b1;
                cpu.err       = err_q;
                state_next    = LSU_IDLE;
            end
            default: state_next = LSU_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            mem_wen_q   <= 1'b0;
            lane_q      <= '0;
            size_q      <= '0;
            unsigned_q  <= 1'b0;
            store_q     <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            if (accept && !misaligned) begin
                mem_addr_q  <= {cpu.addr[31:2], 2'b00};
                mem_wdata_q <= store_data;
                mem_wstrb_q <= store_strb;
                mem_wen_q   <= cpu.is_store;
                lane_q      <= cpu.addr[1:0];
                size_q      <= cpu.size;
                unsigned_q  <= cpu.is_unsigned;
                store_q     <= cpu.is_store;
            end
            if (accept && misaligned) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
            if (resp_take) begin
                rdata_q <= store_q ? 32'h0 : load_data;
                err_q   <= mem.mem_respErr;
            end
        end
    end

    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_wstrb = mem_wstrb_q;
    assign mem.mem_wen   = mem_wen_q;
    assign cpu.rdata     = rdata_q;
endmodule

// File: tb/tb_lsu_core.sv
// Self-checking bench for lsu_core: directed scenarios plus randomized accesses
// checked against a byte-arithmetic reference model.
module tb_lsu_core;
    logic clock = 1'b0;
    logic reset = 1'b1;

    lsu_core_if cpu_if ();
    lsu_mem_if  mem_if ();

    lsu_core dut (
        .clock (clock),
        .reset (reset),
        .cpu   (cpu_if),
        .mem   (mem_if)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes_of(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    // First byte of the accessed lane; word accesses always start at byte 0.
    function automatic int lane_of(input logic [1:0] sz, input logic [31:0] a);
        int n;
        n = nbytes_of(sz);
        return int'(a % 32'd4) / n * n;
    endfunction

    function automatic bit misaligned_of(input logic [1:0] sz, input logic [31:0] a);
        bit check_en;
`ifdef LSU_MISALIGN_CHECK_EN
        check_en = 1'b1;
`else
        check_en = 1'b0;
`endif
        return check_en && ((sz == 2'd3) || (a % nbytes_of(sz) != 0));
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                               input logic [31:0] a, input logic [31:0] md);
        int     n;
        longint v;
        n = nbytes_of(sz);
        if (n == 4) return md;
        v = longint'(md) >> (8 * lane_of(sz, a));
        v = v % (longint'(1) << (8 * n));
        if (!uns && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = nbytes_of(sz);
        for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % n) +: 8];
        return r;
    endfunction

    function automatic logic [3:0] model_strb(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] s;
        int lane;
        int n;
        lane = lane_of(sz, a);
        n    = nbytes_of(sz);
        for (int k = 0; k < 4; k++) s[k] = (k >= lane) && (k < lane + n);
        return s;
    endfunction

    // Junk on the request side while busy; hold keeps reqValid asserted throughout.
    task automatic drive_busy(input bit hold);
        cpu_if.reqValid    = hold ? 1'b1 : 1'($urandom_range(0, 1));
        cpu_if.is_store    = 1'($urandom_range(0, 1));
        cpu_if.size        = 2'($urandom_range(0, 3));
        cpu_if.is_unsigned = 1'($urandom_range(0, 1));
        cpu_if.addr        = $urandom;
        cpu_if.wdata       = $urandom;
    endtask

    // Called and returns at a negedge with the DUT idle.
    task automatic txn(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] md,
                       input logic me, input int rdy_dly, input int rsp_dly, input bit hold,
                       output logic [31:0] got_rdata, output logic got_err);
        bit          mis;
        logic [31:0] exp_rdata;
        logic        exp_err;
        mis       = misaligned_of(sz, a);
        exp_rdata = (st || mis) ? 32'h0 : model_load(sz, uns, a, md);
        exp_err   = mis ? 1'b1 : me;

        check("req_ready_idle", cpu_if.reqReady, 32'd1);
        cpu_if.reqValid    = 1'b1;
        cpu_if.is_store    = st;
        cpu_if.size        = sz;
        cpu_if.is_unsigned = uns;
        cpu_if.addr        = a;
        cpu_if.wdata       = wd;
        @(negedge clock);

        if (!mis) begin
            for (int i = 0; i <= rdy_dly; i++) begin
                drive_busy(hold);
                check("mem_req_valid", mem_if.mem_reqValid, 32'd1);
                check("mem_addr", mem_if.mem_addr, a & 32'hFFFF_FFFC);
                check("mem_wen", mem_if.mem_wen, 32'(st));
                check("mem_wstrb", mem_if.mem_wstrb, st ? 32'(model_strb(sz, a)) : 32'd0);
                if (st) check("mem_wdata", mem_if.mem_wdata, model_wdata(sz, wd));
                check("resp_early_req", cpu_if.respValid, 32'd0);
                check("req_ready_busy", cpu_if.reqReady, 32'd0);
                mem_if.mem_reqReady  = (i == rdy_dly);
                mem_if.mem_respValid = 1'($urandom_range(0, 1));
                mem_if.mem_rdata     = $urandom;
                mem_if.mem_respErr   = 1'($urandom_range(0, 1));
                @(negedge clock);
            end
            mem_if.mem_reqReady = 1'b0;
            for (int i = 0; i <= rsp_dly; i++) begin
                drive_busy(hold);
                check("mem_req_drop", mem_if.mem_reqValid, 32'd0);
                check("resp_early_wait", cpu_if.respValid, 32'd0);
                check("req_ready_busy", cpu_if.reqReady, 32'd0);
                mem_if.mem_respValid = (i == rsp_dly);
                mem_if.mem_rdata     = (i == rsp_dly) ? md : $urandom;
                mem_if.mem_respErr   = (i == rsp_dly) ? me : 1'b0;
                @(negedge clock);
            end
        end

        drive_busy(hold);
        mem_if.mem_respValid = 1'($urandom_range(0, 1));
        mem_if.mem_rdata     = $urandom;
        check("resp_valid", cpu_if.respValid, 32'd1);
        check("rdata", cpu_if.rdata, exp_rdata);
        check("err", cpu_if.err, 32'(exp_err));
        check("req_ready_resp", cpu_if.reqReady, 32'd0);
        check("mem_req_resp", mem_if.mem_reqValid, 32'd0);
        got_rdata = cpu_if.rdata;
        got_err   = cpu_if.err;
        @(negedge clock);

        cpu_if.reqValid      = hold;
        mem_if.mem_respValid = 1'b0;
        check("resp_pulse", cpu_if.respValid, 32'd0);
        check("err_idle", cpu_if.err, 32'd0);
        check("rdata_hold", cpu_if.rdata, exp_rdata);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        logic        exp26;

        cpu_if.reqValid      = 1'b0;
        cpu_if.is_store      = 1'b0;
        cpu_if.size          = 2'd0;
        cpu_if.is_unsigned   = 1'b0;
        cpu_if.addr          = 32'h0;
        cpu_if.wdata         = 32'h0;
        mem_if.mem_reqReady  = 1'b0;
        mem_if.mem_respValid = 1'b0;
        mem_if.mem_rdata     = 32'h0;
        mem_if.mem_respErr   = 1'b0;

        // Power-on reset values
        repeat (2) @(negedge clock);
        check("rst_resp_valid", cpu_if.respValid, 32'd0);
        check("rst_rdata", cpu_if.rdata, 32'd0);
        check("rst_err", cpu_if.err, 32'd0);
        check("rst_mem_req", mem_if.mem_reqValid, 32'd0);
        check("rst_mem_wen", mem_if.mem_wen, 32'd0);
        check("rst_mem_wstrb", mem_if.mem_wstrb, 32'd0);
        check("rst_mem_addr", mem_if.mem_addr, 32'd0);
        check("rst_mem_wdata", mem_if.mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("rst_req_ready", cpu_if.reqReady, 32'd1);

        // Signed byte load from the top lane, zero-wait memory
        txn(1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0, 32'h80AA_BBCC, 1'b0, 0, 0, 1'b0, r, e);
        check("req022_rdata", r, 32'hFFFF_FF80);

        // Reset while the access waits on memory; a late memory response must be dropped
        cpu_if.reqValid = 1'b1;
        cpu_if.is_store = 1'b1;
        cpu_if.size     = 2'd2;
        cpu_if.addr     = 32'h0000_4444;
        cpu_if.wdata    = 32'h5555_AAAA;
        @(negedge clock);
        cpu_if.reqValid = 1'b0;
        check("rst_mid_req_phase", mem_if.mem_reqValid, 32'd1);
        mem_if.mem_reqReady = 1'b1;
        @(negedge clock);
        mem_if.mem_reqReady = 1'b0;
        check("rst_mid_wait_phase", mem_if.mem_reqValid, 32'd0);
        reset = 1'b1;
        #1;
        check("rst_mid_resp_valid", cpu_if.respValid, 32'd0);
        check("rst_mid_mem_wstrb", mem_if.mem_wstrb, 32'd0);
        @(negedge clock);
        reset                = 1'b0;
        mem_if.mem_respValid = 1'b1;
        mem_if.mem_rdata     = 32'hDEAD_BEEF;
        mem_if.mem_respErr   = 1'b1;
        @(negedge clock);
        mem_if.mem_respValid = 1'b0;
        mem_if.mem_respErr   = 1'b0;
        check("rst_late_resp_valid", cpu_if.respValid, 32'd0);
        check("rst_late_req_ready", cpu_if.reqReady, 32'd1);
        check("rst_late_rdata", cpu_if.rdata, 32'd0);
        check("rst_late_err", cpu_if.err, 32'd0);
        check("rst_late_mem_req", mem_if.mem_reqValid, 32'd0);
        check("rst_late_mem_wen", mem_if.mem_wen, 32'd0);
        check("rst_late_mem_wstrb", mem_if.mem_wstrb, 32'd0);
        check("rst_late_mem_addr", mem_if.mem_addr, 32'd0);
        check("rst_late_mem_wdata", mem_if.mem_wdata, 32'd0);
        @(negedge clock);
        check("rst_late_resp_valid2", cpu_if.respValid, 32'd0);

        // Half store, memory not ready for four cycles
        txn(1'b1, 2'd1, 1'b0, 32'h8000_0006, 32'h1234_ABCD, 32'h0, 1'b0, 4, 0, 1'b0, r, e);
        check("req023_rdata", r, 32'd0);

        // reqValid held through a busy access; the next request follows right after respValid
        txn(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'h1122_3344, 1'b0, 1, 2, 1'b1, r, e);
        txn(1'b1, 2'd0, 1'b0, 32'h0000_0101, 32'h0000_00EE, 32'h0, 1'b0, 0, 1, 1'b0, r, e);

        // Word load at a half-aligned address
        txn(1'b0, 2'd2, 1'b0, 32'h0000_1002, 32'h0, 32'hCAFE_F00D, 1'b0, 0, 0, 1'b0, r, e);
`ifdef LSU_MISALIGN_CHECK_EN
        exp26 = 1'b1;
`else
        exp26 = 1'b0;
`endif
        check("req026_err", e, 32'(exp26));

        // Unsigned half load from the upper lane with a memory error
        txn(1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 32'hF00D_1234, 1'b1, 0, 0, 1'b0, r, e);
        check("req027_rdata", r, 32'h0000_F00D);
        check("req027_err", e, 32'd1);

        // Randomized accesses
        for (int t = 0; t < 60; t++) begin
            logic        st;
            logic [1:0]  sz;
            logic        uns;
            logic        me;
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] md;
            bit          hold;
            st   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            uns  = 1'($urandom_range(0, 1));
            me   = ($urandom_range(0, 4) == 0);
            a    = $urandom;
            wd   = $urandom;
            md   = $urandom;
            hold = (t < 59) && ($urandom_range(0, 3) == 0);
            txn(st, sz, uns, a, wd, md, me, $urandom_range(0, 3), $urandom_range(0, 3), hold, r, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_core.md
LSU_CORE -- requirements
Module: lsu_core

Interface
REQ-001 SHALL have ports: clock  in  1  system clock; reset  in  1  asynchronous, active-high.
REQ-002 SHALL have ports: reqValid in 1 access request; reqReady out 1 request accepted this cycle; is_store in 1 store=1/load=0; size in 2 (0 byte, 1 half, 2 word, 3 reserved); is_unsigned in 1 zero-extend load.
REQ-003 SHALL have ports: addr in 32 byte address; wdata in 32 store data (low-aligned); respValid out 1 one-cycle completion pulse; rdata out 32 extended load data; err out 1 access error, valid with respValid.
REQ-004 SHALL have memory ports: mem_reqValid out 1; mem_reqReady in 1; mem_wen out 1; mem_addr out 32; mem_wdata out 32; mem_wstrb out 4; mem_respValid in 1; mem_rdata in 32; mem_respErr in 1.

Function
REQ-005 SHALL implement states LSU_IDLE, LSU_REQ, LSU_WAIT, LSU_RESP.
REQ-006 SHALL assert reqReady only in LSU_IDLE; reqValid&reqReady captures is_store, size, is_unsigned, addr, wdata and moves to LSU_REQ.
REQ-007 SHALL ignore reqValid in any state other than LSU_IDLE (no queuing).
REQ-008 SHALL in LSU_REQ hold mem_reqValid=1 with stable mem_* fields until mem_reqReady=1, then move to LSU_WAIT.
REQ-009 SHALL in LSU_WAIT sample mem_respValid; on 1 register mem_rdata/mem_respErr and move to LSU_RESP; mem_respValid outside LSU_WAIT is ignored.
REQ-010 SHALL assert respValid for exactly one cycle in LSU_RESP, then return to LSU_IDLE; a new request is accepted the following cycle at earliest.
REQ-011 SHALL give minimum latency of 3 cycles (accept cycle N, mem_reqReady at N+1, mem_respValid at N+2, respValid at N+3).
REQ-012 SHALL drive mem_addr = {addr[31:2],2'b00}, mem_wen = is_store.
REQ-013 SHALL drive stores: byte -> mem_wdata={4{wdata[7:0]}}, mem_wstrb=4'b0001<<addr[1:0]; half -> {2{wdata[15:0]}}, 4'b0011<<(2*addr[1]); word -> wdata, 4'b1111; loads drive mem_wstrb=0.
REQ-014 SHALL for loads select lane by addr[1:0] (byte) or addr[1] (half) and sign-extend unless is_unsigned; word passes through.
REQ-015 SHALL drive rdata=0 on store completion; rdata holds its value between respValid pulses.
REQ-016 SHALL drive err = registered mem_respErr (plus REQ-020 when enabled) on respValid, 0 otherwise.

Reset
REQ-017 SHALL on reset enter LSU_IDLE with respValid=0, rdata=0, err=0, mem_reqValid=0, mem_wen=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, reqReady=1 after release.
REQ-018 SHALL abandon any in-flight transaction on reset mid-operation without emitting respValid; late mem_respValid after reset is ignored (REQ-009).

Configuration
REQ-019 SHALL use macro LSU_MISALIGN_CHECK_EN.
REQ-020 With LSU_MISALIGN_CHECK_EN: half with addr[0]=1, word with addr[1:0]!=0, or size=3 skip LSU_REQ/LSU_WAIT, go LSU_IDLE->LSU_RESP directly, respValid next cycle with err=1, rdata=0, no memory access.
REQ-021 Without LSU_MISALIGN_CHECK_EN: low address bits beyond lane selection are ignored (half uses addr[1], word uses none), size=3 treated as word, err reflects mem_respErr only.

Verification
REQ-022 Load byte addr=0x8000_0003 signed, mem_rdata=0x80AA_BBCC, zero-wait memory -> respValid at N+3, rdata=0xFFFF_FF80, mem_addr=0x8000_0000.
REQ-023 Store half addr=0x8000_0006 wdata=0x1234_ABCD, mem_reqReady low 4 cycles -> mem_reqValid held 5 cycles, mem_wdata=0xABCD_ABCD, mem_wstrb=4'b1100, respValid once, rdata=0.
REQ-024 reqValid held high during busy transaction -> reqReady=0, second request accepted only the cycle after respValid; exactly one mem_reqValid handshake per accepted request.
REQ-025 Reset asserted in LSU_WAIT, then mem_respValid=1 after release -> no respValid, state LSU_IDLE, all outputs at reset values.
REQ-026 Load word addr=0x1002 with LSU_MISALIGN_CHECK_EN -> respValid next cycle, err=1, mem_reqValid never asserted; without macro -> access at 0x1000, err=0.
REQ-027 Load half unsigned addr=0x2002, mem_rdata=0xF00D_1234, mem_respErr=1 -> rdata=0x0000_F00D, err=1.
